// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: zero-stall hits, whole-line refill on miss.
// A miss stalls the CPU through one IDLE cycle, the memory read and one UPDATE cycle.
module icache_direct_mapped #(
  parameter int unsigned NUM_BLOCKS  = 8,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned ADDR_BITS   = 10
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              PC,
  output logic [31:0]              INSTRUCTION,
  output logic                     BUSYWAIT,
  output logic                     MEM_READ,
  output logic [ADDR_BITS-5:0]     MEM_ADDRESS,
  input  logic [32*BLOCK_WORDS-1:0] MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);

  localparam int unsigned IDX_W  = $clog2(NUM_BLOCKS);
  localparam int unsigned OFF_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned LINE_W = 32 * BLOCK_WORDS;
  localparam int unsigned TAG_W  = ADDR_BITS - IDX_W - OFF_W - 2;
  localparam int unsigned BLK_W  = TAG_W + IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

  state_t                state;
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [LINE_W-1:0]     fill_q;
  logic [31:0]           instr_q;

  logic [TAG_W-1:0]      pc_tag;
  logic [IDX_W-1:0]      pc_idx;
  logic [OFF_W-1:0]      pc_off;
  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic [LINE_W-1:0]     hit_line;
  logic [31:0]           hit_word;
  logic                  hit;
  logic                  unused_pc;

  assign pc_tag    = PC[ADDR_BITS-1 -: TAG_W];
  assign pc_idx    = PC[2+OFF_W +: IDX_W];
  assign pc_off    = PC[2 +: OFF_W];
  assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};
  assign fill_idx  = MEM_ADDRESS[IDX_W-1:0];
  assign fill_tag  = MEM_ADDRESS[BLK_W-1 -: TAG_W];

  // Lookup for the current PC
  always_comb begin
    hit_line = data_q[pc_idx];
    hit_word = hit_line[{pc_off, 5'b0} +: 32];
    hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  end

  // Stall and instruction are needed in the same cycle as the lookup; reset forces both quiet
  always_comb begin
    BUSYWAIT    = 1'b0;
    INSTRUCTION = instr_q;
    if (RESET) begin
      BUSYWAIT = (state != S_IDLE) || !hit;
      if ((state == S_IDLE) && hit) INSTRUCTION = hit_word;
    end
  end

  // Miss handling FSM with registered memory request
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      valid_q     <= '0;
      MEM_READ    <= 1'b0;
      MEM_ADDRESS <= '0;
      fill_q      <= '0;
      instr_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            instr_q <= hit_word;
          end else begin
            MEM_ADDRESS <= {pc_tag, pc_idx};
            MEM_READ    <= 1'b1;
            state       <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            fill_q   <= MEM_READDATA;
            MEM_READ <= 1'b0;
            state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          valid_q[fill_idx] <= 1'b1;
          state             <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line storage needs no reset; valid bits gate its use
  always_ff @(posedge CLK) begin
    if (state == S_UPDATE) begin
      data_q[fill_idx] <= fill_q;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: directed vector table, reset-abort sequence and
// random fetches checked against a line-presence model of the cache.
module tb_icache_direct_mapped;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT = 1'b0;

  int total = 0;
  int bad   = 0;
  int mem_lat = 1;
  int mem_cnt = 0;

  bit       vm [8];
  bit [2:0] tm [8];

  icache_direct_mapped dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: every word holds its own byte address; answers after mem_lat read cycles
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++)
      MEM_READDATA[32*i +: 32] = {22'd0, MEM_ADDRESS, 2'(i), 2'b00};
    if (MEM_READ) begin
      MEM_BUSYWAIT = (mem_cnt < mem_lat - 1);
      mem_cnt++;
    end else begin
      MEM_BUSYWAIT = 1'b0;
      mem_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a line is present iff its index was last filled with this tag since reset
  task automatic model_access(input logic [31:0] pc, output bit hit);
    int idx;
    idx = int'(pc[6:4]);
    hit = vm[idx] && (tm[idx] == pc[9:7]);
    vm[idx] = 1'b1;
    tm[idx] = pc[9:7];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      vm[i] = 1'b0;
      tm[i] = 3'd0;
    end
  endtask

  // Called just after a posedge; returns just after the posedge following the completed fetch
  task automatic fetch(input logic [31:0] pc, input int lat, input int exp_stall,
                       input logic [5:0] exp_addr, input logic [31:0] exp_instr);
    int stall;
    int mr;
    int guard;
    logic [5:0] seen_addr;
    stall = 0; mr = 0; guard = 0; seen_addr = '0;
    mem_lat = lat;
    PC = pc;
    @(negedge CLK);
    while (BUSYWAIT === 1'b1 && guard < 100) begin
      stall++;
      if (MEM_READ) begin
        mr++;
        seen_addr = MEM_ADDRESS;
      end
      guard++;
      @(negedge CLK);
    end
    if (guard >= 100) begin
      total++; bad++;
      $display("FAIL timeout: BUSYWAIT stuck at pc %h", pc);
    end
    check("stall_cycles", 32'(stall), 32'(exp_stall));
    check("mem_read_cycles", 32'(mr), (exp_stall == 0) ? 32'd0 : 32'(lat));
    if (exp_stall != 0) check("mem_address", 32'(seen_addr), 32'(exp_addr));
    check("instruction", INSTRUCTION, exp_instr);
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    int          lat;
    int          stall;
    logic [5:0]  addr;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit hit;
    logic [31:0] pc;
    int lat;
    int guard;

    vecs[0] = '{32'h0000_0000, 5, 7, 6'd0,  32'h0000_0000};
    vecs[1] = '{32'h0000_0004, 1, 0, 6'd0,  32'h0000_0004};
    vecs[2] = '{32'h0000_0008, 1, 0, 6'd0,  32'h0000_0008};
    vecs[3] = '{32'h0000_000C, 1, 0, 6'd0,  32'h0000_000C};
    vecs[4] = '{32'h0000_0080, 3, 5, 6'd8,  32'h0000_0080};
    vecs[5] = '{32'h0000_0000, 2, 4, 6'd0,  32'h0000_0000};
    vecs[6] = '{32'h0000_0407, 1, 0, 6'd0,  32'h0000_0004};
    vecs[7] = '{32'h0000_03F0, 1, 3, 6'd63, 32'h0000_03F0};
    vecs[8] = '{32'hFFFF_F3FC, 1, 0, 6'd0,  32'h0000_03FC};
    vecs[9] = '{32'h0000_0084, 4, 6, 6'd8,  32'h0000_0084};

    RESET = 1'b0;
    PC = 32'h0;
    model_clear();
    #1;
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    check("rst_instruction", INSTRUCTION, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;

    for (int i = 0; i < 10; i++) begin
      fetch(vecs[i].pc, vecs[i].lat, vecs[i].stall, vecs[i].addr, vecs[i].instr);
      model_access(vecs[i].pc, hit);
    end

    // Reset during an outstanding read aborts it immediately and leaves the line invalid
    mem_lat = 5;
    PC = 32'h0000_0010;
    guard = 0;
    @(negedge CLK);
    while (MEM_READ !== 1'b1 && guard < 20) begin
      guard++;
      @(negedge CLK);
    end
    check("abort_mem_read_before", 32'(MEM_READ), 32'd1);
    #1;
    RESET = 1'b0;
    #1;
    check("abort_mem_read", 32'(MEM_READ), 32'd0);
    check("abort_busywait", 32'(BUSYWAIT), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check("abort_mem_address", 32'(MEM_ADDRESS), 32'd0);
    check("abort_instruction", INSTRUCTION, 32'd0);
    model_clear();
    RESET = 1'b1;
    fetch(32'h0000_0010, 5, 7, 6'd1, 32'h0000_0010);
    model_access(32'h0000_0010, hit);

    // Random fetches over a few tags so hits, cold misses and conflicts all occur
    for (int n = 0; n < 200; n++) begin
      pc = $urandom();
      pc[9:7] = 3'($urandom_range(0, 2));
      lat = int'($urandom_range(1, 4));
      model_access(pc, hit);
      fetch(pc, lat, hit ? 0 : lat + 2, pc[9:4], {22'd0, pc[9:2], 2'b00});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
